cordic_axi4s_arbiter: RTL
=========================

# cordic_axi4s_arbiter

Round-robin AXI4-S arbiter that shares one fixed-latency, in-order compute resource between several requesters, such as the CORDIC or long divider used by several IIR biquad filters. Requests are granted packet by packet (tlast-locked) onto a single egress stream. An in-order grant FIFO routes each response packet back to the requester that issued it. It sits between the filter tops and the shared `cordic_axi4s_if` / `long_division_axi4s_if` instance in the DSP system.

## Interface
- NR_OF_MASTERS_P, 4, number of requesters (2..16)
- AXI_DATA_WIDTH_P, 32, request tdata width
- RSP_DATA_WIDTH_P, 64, response tdata width (2*AXI_DATA_WIDTH_P for the CORDIC)
- AXI_ID_WIDTH_P, 32, tid width, passed through untouched
- MAX_OUTSTANDING_P, 16, grant FIFO depth, i.e. the maximum number of packets in flight
- Clock and reset: one clock; reset is asynchronous and active-low.

Ports (N = NR_OF_MASTERS_P):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_tvalid / req_tready  in / out  N  per-requester handshake
- req_tdata  in  N x AXI_DATA_WIDTH_P  request payload
- req_tlast / req_tuser  in  N  end of packet / user bit
- req_tid  in  N x AXI_ID_WIDTH_P  request id
- egr_tvalid / egr_tready  out / in  1  handshake to the shared resource
- egr_tdata / egr_tlast / egr_tid / egr_tuser  out  as above  muxed request beat
- ing_tvalid / ing_tready  in / out  1  response handshake from the resource
- ing_tdata  in  RSP_DATA_WIDTH_P  response payload
- ing_tlast  in  1  response end of packet
- ing_tid  in  AXI_ID_WIDTH_P  response id
- rsp_tvalid / rsp_tready  out / in  N  per-requester response handshake
- rsp_tdata / rsp_tlast / rsp_tid  out  N x widths  response broadcast to all requesters
- sr_outstanding  out  $clog2(MAX_OUTSTANDING_P+1)  packets granted but not yet answered
- sr_rsp_err  out  1  sticky: a response arrived with no packet outstanding

## Operation
- Grant FSM states:
  - IDLE: egr_tvalid=0 and all req_tready=0. If any req_tvalid is set and the FIFO is not full, select the first requester with valid set, searching from rr_ptr upward with wrap at N-1→0. Register grant g, push g into the grant FIFO, go to LOCKED.
  - LOCKED: combinational pass-through of requester g: egr_* = req_*[g], req_tready[g] = egr_tready, other req_tready = 0. On an egress handshake with egr_tlast=1, set rr_ptr = (g+1) mod N and go to IDLE.
- The grant decision and FIFO push happen only in IDLE. Valid changes on other requesters during LOCKED are ignored.
- FIFO full in IDLE: stay in IDLE with no grant and no push.
- Response routing, purely combinational from the FIFO head h:
  - rsp_tvalid[h] = ing_tvalid; all other rsp_tvalid = 0.
  - ing_tready = FIFO not empty AND rsp_tready[h].
  - rsp_tdata, rsp_tlast and rsp_tid are broadcast to all requesters.
- Pop the FIFO on an ing handshake with ing_tlast=1.
- Empty FIFO: ing_tready=0 and all rsp_tvalid=0. If ing_tvalid=1 in this condition, set sr_rsp_err (sticky until reset). The beat is not accepted.
- Push and pop in the same cycle: sr_outstanding is unchanged, and a full FIFO stays legal because the push precedes the grant decision next cycle.
- Resources without backpressure (the CORDIC) require rsp_tready=1 at every requester. The system ties these high.
- Reset, including mid-packet:
  - FSM → IDLE, rr_ptr=0, FIFO emptied, sr_outstanding=0, sr_rsp_err=0.
  - Outputs: egr_tvalid=0, req_tready=0, rsp_tvalid=0, ing_tready=0.
  - The partial packet is dropped. Requesters must also be reset.

## Timing
- Request path:
  - Arbitration latency is 1 cycle: req_tvalid high in IDLE at cycle t gives egr_tvalid at t+1.
  - Within a packet, beats pass through with 0 latency and full throughput.
  - Between packets there is one bubble cycle (IDLE). Single-beat packets therefore sustain 1 beat per 2 cycles.
- Response path: 0-cycle combinational, full throughput.
- sr_outstanding updates the cycle after a push or pop.
- Fairness: with all N requesters permanently valid, each is granted exactly once every N packets.

## Test plan
- Single requester 2, single-beat packet 0x1234 → egr_tdata=0x1234 one cycle after req_tvalid. A response 0xABCD with tlast returns on rsp_tvalid[2] only. sr_outstanding goes 0→1→0.
- All 4 requesters valid continuously with single-beat packets, starting from reset → grant order 0,1,2,3,0,1,… and egr_tvalid high every other cycle.
- Requester 1 sends a 3-beat packet while requester 0 is valid → the three beats of requester 1 are contiguous on egr, and requester 0 is granted only after egr_tlast.
- Responses withheld with MAX_OUTSTANDING_P=16 → no grants after 16 pushes. Injecting a response and a new request in the same cycle keeps sr_outstanding=16, then grants resume.
- ing_tvalid=1 with an empty FIFO → ing_tready=0, no rsp_tvalid, sr_rsp_err=1 and held until rst_n.
- Assert rst_n=0 during beat 2 of a 3-beat packet with 5 outstanding → all outputs and sr_outstanding read 0 immediately. After reset, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/cordic_axi4s_arbiter.sv
// ============================================================================
// Module : cordic_axi4s_arbiter
// Brief  : Packet-locked round-robin AXI4-S arbiter sharing one in-order
//          compute resource; a grant FIFO routes responses back to requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cordic_axi4s_arbiter #(
    parameter int NR_OF_MASTERS_P   = 4,
    parameter int AXI_DATA_WIDTH_P  = 32,
    parameter int RSP_DATA_WIDTH_P  = 64,
    parameter int AXI_ID_WIDTH_P    = 32,
    parameter int MAX_OUTSTANDING_P = 16
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NR_OF_MASTERS_P-1:0]                       req_tvalid,
    output logic [NR_OF_MASTERS_P-1:0]                       req_tready,
    input  logic [NR_OF_MASTERS_P-1:0][AXI_DATA_WIDTH_P-1:0] req_tdata,
    input  logic [NR_OF_MASTERS_P-1:0]                       req_tlast,
    input  logic [NR_OF_MASTERS_P-1:0]                       req_tuser,
    input  logic [NR_OF_MASTERS_P-1:0][AXI_ID_WIDTH_P-1:0]   req_tid,
    output logic                                             egr_tvalid,
    input  logic                                             egr_tready,
    output logic [AXI_DATA_WIDTH_P-1:0]                      egr_tdata,
    output logic                                             egr_tlast,
    output logic [AXI_ID_WIDTH_P-1:0]                        egr_tid,
    output logic                                             egr_tuser,
    input  logic                                             ing_tvalid,
    output logic                                             ing_tready,
    input  logic [RSP_DATA_WIDTH_P-1:0]                      ing_tdata,
    input  logic                                             ing_tlast,
    input  logic [AXI_ID_WIDTH_P-1:0]                        ing_tid,
    output logic [NR_OF_MASTERS_P-1:0]                       rsp_tvalid,
    input  logic [NR_OF_MASTERS_P-1:0]                       rsp_tready,
    output logic [NR_OF_MASTERS_P-1:0][RSP_DATA_WIDTH_P-1:0] rsp_tdata,
    output logic [NR_OF_MASTERS_P-1:0]                       rsp_tlast,
    output logic [NR_OF_MASTERS_P-1:0][AXI_ID_WIDTH_P-1:0]   rsp_tid,
    output logic [$clog2(MAX_OUTSTANDING_P+1)-1:0]           sr_outstanding,
    output logic                                             sr_rsp_err
);

    localparam int GW = $clog2(NR_OF_MASTERS_P);
    localparam int PW = (MAX_OUTSTANDING_P > 1) ? $clog2(MAX_OUTSTANDING_P) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING_P + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state, w_next_state;
    logic [GW-1:0]   r_grant, r_rr_ptr, w_sel, w_idx, w_head;
    logic            w_sel_valid, w_push, w_pop, w_full, w_empty, w_can_push, w_egr_last_hs;
    logic [GW-1:0]   r_fifo [MAX_OUTSTANDING_P];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING_P));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_pop   = ing_tvalid && ing_tready && ing_tlast;
    // A pop in the same cycle frees the slot, so a full FIFO may still grant.
    assign w_can_push    = !w_full || w_pop;
    assign w_egr_last_hs = egr_tvalid && egr_tready && egr_tlast;

    // Walk downward so the lowest offset from rr_ptr is the final winner.
    always_comb begin
        w_sel       = r_rr_ptr;
        w_idx       = r_rr_ptr;
        w_sel_valid = 1'b0;
        for (int i = NR_OF_MASTERS_P - 1; i >= 0; i--) begin
            w_idx = GW'((32'(r_rr_ptr) + i) % NR_OF_MASTERS_P);
            if (req_tvalid[w_idx]) begin
                w_sel       = w_idx;
                w_sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        req_tready   = '0;
        egr_tvalid   = 1'b0;
        egr_tdata    = req_tdata[r_grant];
        egr_tlast    = req_tlast[r_grant];
        egr_tid      = req_tid[r_grant];
        egr_tuser    = req_tuser[r_grant];
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid && w_can_push) begin
                    w_push       = 1'b1;
                    w_next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                egr_tvalid          = req_tvalid[r_grant];
                req_tready[r_grant] = egr_tready;
                if (w_egr_last_hs) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_grant <= w_sel;
            end
            if (r_state == ST_LOCKED && w_egr_last_hs) begin
                r_rr_ptr <= (r_grant == GW'(NR_OF_MASTERS_P - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            sr_rsp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(MAX_OUTSTANDING_P - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUTSTANDING_P - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (ing_tvalid && w_empty) begin
                sr_rsp_err <= 1'b1;
            end
        end
    end

    assign sr_outstanding = r_count;

    always_comb begin
        rsp_tvalid = '0;
        ing_tready = 1'b0;
        if (!w_empty) begin
            rsp_tvalid[w_head] = ing_tvalid;
            ing_tready         = rsp_tready[w_head];
        end
    end

    generate
        for (genvar g = 0; g < NR_OF_MASTERS_P; g++) begin : g_rsp_bcast
            assign rsp_tdata[g] = ing_tdata;
            assign rsp_tlast[g] = ing_tlast;
            assign rsp_tid[g]   = ing_tid;
        end
    endgenerate

endmodule

`default_nettype wire
